// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline front end.
//   - PC_SRC_* : jump-unit select encodings (2'b11 is handled like a branch)
//   - NOP_INSTR / RESET_PC : default bubble instruction and reset fetch address
//   - fetch_state_e : fetch sequencer states
package mips_pkg;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   // BOOT : one idle cycle out of reset, no request
   // FETCH: request outstanding at pc
   // HOLD : instruction captured while the pipe was stalled, no request
   // DRAIN: redirected while a request was still waiting; finish it and drop it
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bundle.
//   req   : fetch request (master -> slave); addr stable while req=1 and ready=0
//   addr  : fetch address  (master -> slave)
//   rdata : instruction    (slave -> master), valid when ready=1
//   ready : request accepted / data valid in the same cycle
interface fetch_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output req, output addr, input rdata, input ready);
   modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   i_flush : load a bubble {NOP_INSTR, pc4 unchanged, valid=0}; beats everything
//   i_hold  : keep the current contents (pipeline stalled)
//   i_load  : capture {i_instr, i_pc4, valid=1}
//   o_instr / o_pc4 / o_valid : register contents
// With no control asserted the register keeps its contents.
module if_id_reg #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_flush,
   input  logic              i_hold,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [ADDR_W-1:0] i_pc4,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc4,
   output logic              o_valid
);

   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;

   // NOTE: every signal assigned in always_comb gets a default first so no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (i_flush) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (i_load && !i_hold) begin
         instr_d = i_instr;
         pc4_d   = i_pc4;
         valid_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign o_instr = instr_q;
   assign o_pc4   = pc4_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_stall                     : hazard unit freeze of PC and IF/ID
//   i_pc_src, i_kill1           : jump unit redirect select / IF flush
//   i_jump_target, i_branch_target : redirect destinations
//   imem                        : instruction-memory request bundle (master side)
//   o_if_instr, o_if_pc4, o_if_valid : IF/ID register contents
// A kill with a non-sequential pc_src redirects the PC; any kill flushes IF/ID.
// Kill beats stall. A redirect that arrives while a request is still waiting
// goes through DRAIN so the address never changes under an outstanding request.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(mips_pkg::RESET_PC),
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(mips_pkg::NOP_INSTR)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stall,
   input  logic [1:0]        i_pc_src,
   input  logic              i_kill1,
   input  logic [ADDR_W-1:0] i_jump_target,
   input  logic [ADDR_W-1:0] i_branch_target,
   fetch_stage_if.master     imem,
   output logic [DATA_W-1:0] o_if_instr,
   output logic [ADDR_W-1:0] o_if_pc4,
   output logic              o_if_valid
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;   // redirect saved during DRAIN
   logic [DATA_W-1:0] hold_q, hold_d;       // instruction captured under stall

   logic              redirect;
   logic [ADDR_W-1:0] target_raw;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc_plus4;
   logic              req;
   logic              ifid_load;
   logic              ifid_flush;
   logic              ifid_hold;
   logic [DATA_W-1:0] ifid_instr;

   // pc_src=00 with kill1 only flushes IF/ID; the PC follows its normal rules
   assign redirect   = i_kill1 && (i_pc_src != PC_SRC_SEQ);
   assign target_raw = i_pc_src[1] ? i_branch_target : i_jump_target;
   assign target     = target_raw & ~ADDR_W'(3);
   assign pc_plus4   = pc_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      target_d   = target_q;
      hold_d     = hold_q;
      req        = 1'b0;
      ifid_load  = 1'b0;
      ifid_flush = i_kill1;
      ifid_hold  = i_stall;
      ifid_instr = imem.rdata;

      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            if (redirect) pc_d = target;
         end

         ST_FETCH: begin
            req = 1'b1;
            if (redirect) begin
               if (imem.ready) begin
                  pc_d = target;
               end else begin
                  target_d = target;
                  state_d  = ST_DRAIN;
               end
            end else if (imem.ready) begin
               if (i_stall) begin
                  hold_d  = imem.rdata;
                  state_d = ST_HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end
            end else if (!i_stall) begin
               ifid_flush = 1'b1;   // nothing arrived: ID sees a bubble
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               hold_d  = NOP_INSTR;
               pc_d    = target;
               state_d = ST_FETCH;
            end else if (!i_stall) begin
               ifid_load  = 1'b1;
               ifid_instr = hold_q;
               pc_d       = pc_plus4;
               state_d    = ST_FETCH;
            end
         end

         ST_DRAIN: begin
            req        = 1'b1;
            ifid_flush = 1'b1;
            if (redirect) target_d = target;   // newest redirect wins
            if (imem.ready) begin
               pc_d    = redirect ? target : target_q;
               state_d = ST_FETCH;
            end
         end

         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         target_q <= '0;
         hold_q   <= NOP_INSTR;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         hold_q   <= hold_d;
      end
   end

   assign imem.req  = req;
   assign imem.addr = pc_q;

   if_id_reg #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_load (ifid_load),
      .i_flush(ifid_flush),
      .i_hold (ifid_hold),
      .i_instr(ifid_instr),
      .i_pc4  (pc_plus4),
      .o_instr(o_if_instr),
      .o_pc4  (o_if_pc4),
      .o_valid(o_if_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
// The stimulus task advances a transaction-level model (next fetch address,
// one outstanding request, one parked instruction) and queues the expected
// per-cycle request and the expected instruction stream into IF/ID. A monitor
// on the falling edge pops and compares. A second instance with
// RESET_PC=0xFFFF_FFFC shares the inputs and is checked for address wrap.
module tb_fetch_stage;
   import mips_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic          req;
      logic [AW-1:0] addr;
   } cyc_t;

   typedef struct {
      logic [DW-1:0] instr;
      logic [AW-1:0] pc4;
   } ins_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          kill1 = 1'b0;
   logic [1:0]    pc_src = 2'b00;
   logic [AW-1:0] jt = '0;
   logic [AW-1:0] bt = '0;
   logic          ready = 1'b0;
   logic [DW-1:0] junk = '0;

   logic [DW-1:0] if_instr, if_instr2;
   logic [AW-1:0] if_pc4, if_pc42;
   logic          if_valid, if_valid2;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) imem_bus ();
   fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) imem_bus2 ();

   // read data is only meaningful with ready; otherwise drive garbage
   assign imem_bus.ready  = ready;
   assign imem_bus.rdata  = ready ? mem_word(imem_bus.addr) : junk;
   assign imem_bus2.ready = ready;
   assign imem_bus2.rdata = ready ? mem_word(imem_bus2.addr) : junk;

   fetch_stage u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_stall        (stall),
      .i_pc_src       (pc_src),
      .i_kill1        (kill1),
      .i_jump_target  (jt),
      .i_branch_target(bt),
      .imem           (imem_bus),
      .o_if_instr     (if_instr),
      .o_if_pc4       (if_pc4),
      .o_if_valid     (if_valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_stall        (stall),
      .i_pc_src       (pc_src),
      .i_kill1        (kill1),
      .i_jump_target  (jt),
      .i_branch_target(bt),
      .imem           (imem_bus2),
      .o_if_instr     (if_instr2),
      .o_if_pc4       (if_pc42),
      .o_if_valid     (if_valid2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   cyc_t          exp_cyc[$];
   ins_t          exp_ins[$];
   logic          m_boot, m_pending, m_inflight, m_doomed;
   logic [AW-1:0] m_next, m_cur;
   ins_t          m_pend;

   task automatic model_reset();
      m_boot     = 1'b1;
      m_pending  = 1'b0;
      m_inflight = 1'b0;
      m_doomed   = 1'b0;
      m_next     = 32'h0;
      m_cur      = 32'h0;
      exp_cyc.delete();
      exp_ins.delete();
   endtask

   // One cycle: predict this cycle's request, then what the coming edge does.
   task automatic model_step();
      logic          redirect;
      logic          ent;
      logic [AW-1:0] tgt;
      logic [AW-1:0] addr;
      cyc_t          c;
      ins_t          e;
      redirect = kill1 && (pc_src != 2'b00);
      tgt      = pc_src[1] ? bt : jt;
      tgt[1:0] = 2'b00;
      addr     = m_inflight ? m_cur : m_next;
      c.req    = !m_boot && !m_pending;
      c.addr   = addr;
      exp_cyc.push_back(c);
      ent = 1'b0;
      e   = m_pend;
      if (m_boot) begin
         m_boot = 1'b0;
         if (redirect) m_next = tgt;
      end else if (m_pending) begin
         if (redirect) begin
            m_pending = 1'b0;
            m_next    = tgt;
         end else if (!stall) begin
            ent       = 1'b1;
            m_pending = 1'b0;
         end
      end else if (ready) begin
         m_inflight = 1'b0;
         if (m_doomed || redirect) begin
            m_doomed = 1'b0;
            if (redirect) m_next = tgt;
         end else begin
            m_next  = addr + 32'd4;
            e.instr = mem_word(addr);
            e.pc4   = addr + 32'd4;
            if (stall) begin
               m_pending = 1'b1;
               m_pend    = e;
            end else begin
               ent = 1'b1;
            end
         end
      end else begin
         m_inflight = 1'b1;
         m_cur      = addr;
         if (redirect) begin
            m_doomed = 1'b1;
            m_next   = tgt;
         end
      end
      // anything entering IF/ID on a kill edge is flushed away
      if (ent && !kill1) exp_ins.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic          mon_en = 1'b0;
   logic          prev_stall = 1'b0;
   logic          prev_kill = 1'b0;
   logic [DW-1:0] last_instr = '0;
   logic [AW-1:0] last_pc4 = '0;
   cyc_t          mc;
   ins_t          mi;

   always @(negedge clk) begin
      if (mon_en) begin
         check("cyc_queue_nonempty", 32'(exp_cyc.size() != 0), 32'd1);
         if (exp_cyc.size() != 0) begin
            mc = exp_cyc.pop_front();
            check("imem_req", 32'(imem_bus.req), 32'(mc.req));
            if (mc.req) check("imem_addr", imem_bus.addr, mc.addr);
         end
         // IF/ID only keeps its contents across an edge with stall and no kill
         if (if_valid && (!prev_stall || prev_kill)) begin
            check("ins_queue_nonempty", 32'(exp_ins.size() != 0), 32'd1);
            if (exp_ins.size() != 0) begin
               mi = exp_ins.pop_front();
               check("if_instr", if_instr, mi.instr);
               check("if_pc4", if_pc4, mi.pc4);
            end
         end else if (if_valid) begin
            check("held_instr", if_instr, last_instr);
            check("held_pc4", if_pc4, last_pc4);
         end else begin
            check("bubble_instr", if_instr, 32'h0);
         end
         last_instr = if_instr;
         last_pc4   = if_pc4;
         prev_stall = stall;
         prev_kill  = kill1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic s, input logic k, input logic [1:0] src,
                      input logic [AW-1:0] j, input logic [AW-1:0] b, input logic r);
      stall  = s;
      kill1  = k;
      pc_src = src;
      jt     = j;
      bt     = b;
      ready  = r;
      junk   = $urandom;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, '0, '0, r);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      stall  = 1'b0;
      kill1  = 1'b0;
      pc_src = 2'b00;
      ready  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      prev_stall = 1'b0;
      prev_kill  = 1'b0;
      mon_en     = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_bus.req), 32'd0);
      check("rst_addr", imem_bus.addr, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_pc4", if_pc4, 32'h0);
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_addr_wrap", imem_bus2.addr, 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // zero-wait streaming, then jump to 0x100 while fetching 0x8
      cyc(0, 0, 2'b00, '0, '0, 1);           // BOOT
      #2;
      check("wrap_req", 32'(imem_bus2.req), 32'd1);
      check("wrap_addr0", imem_bus2.addr, 32'hFFFF_FFFC);
      cyc(0, 0, 2'b00, '0, '0, 1);           // fetch 0x0 / 0xFFFFFFFC
      #2;
      check("wrap_addr1", imem_bus2.addr, 32'h0);
      check("wrap_pc4", if_pc42, 32'h0);
      check("wrap_instr", if_instr2, mem_word(32'hFFFF_FFFC));
      cyc(0, 0, 2'b00, '0, '0, 1);           // fetch 0x4
      check("pc4_after_0x4", if_pc4, 32'h8);
      cyc(0, 1, 2'b01, 32'h100, '0, 1);      // fetch 0x8 killed
      #2;
      check("jump_addr", imem_bus.addr, 32'h100);
      check("jump_bubble", 32'(if_valid), 32'd0);
      cyc(0, 0, 2'b00, '0, '0, 1);
      #2;
      check("jump_pc4", if_pc4, 32'h104);
      idle(2, 1);

      // two-wait memory, branch during a wait, then a second kill in DRAIN
      do_reset();
      idle(3, 1);                            // BOOT, 0x0, 0x4
      cyc(0, 0, 2'b00, '0, '0, 0);           // 0x8 wait 1
      cyc(0, 1, 2'b10, '0, 32'h40, 0);       // 0x8 wait 2 + branch
      #2;
      check("drain_addr_hold", imem_bus.addr, 32'h8);
      cyc(0, 0, 2'b00, '0, '0, 1);           // 0x8 completes, dropped
      #2;
      check("branch_addr", imem_bus.addr, 32'h40);
      idle(2, 0);
      idle(1, 1);                            // 0x40 after two waits
      cyc(0, 0, 2'b00, '0, '0, 0);           // 0x44 wait
      cyc(0, 1, 2'b11, '0, 32'h60, 0);       // pc_src=11 acts as branch
      cyc(0, 1, 2'b01, 32'h80, '0, 0);       // newer kill in DRAIN
      #2;
      check("drain2_addr_hold", imem_bus.addr, 32'h44);
      cyc(0, 0, 2'b00, '0, '0, 1);
      #2;
      check("newest_target", imem_bus.addr, 32'h80);
      idle(3, 1);

      // three stall cycles with ready memory
      cyc(1, 0, 2'b00, '0, '0, 1);
      #2;
      check("hold_req", 32'(imem_bus.req), 32'd0);
      cyc(1, 0, 2'b00, '0, '0, 1);
      cyc(1, 0, 2'b00, '0, '0, 1);
      idle(3, 1);

      // kill + stall while holding: flush wins
      cyc(1, 0, 2'b00, '0, '0, 1);
      cyc(1, 1, 2'b01, 32'h200, '0, 1);
      #2;
      check("hold_kill_addr", imem_bus.addr, 32'h200);
      check("hold_kill_valid", 32'(if_valid), 32'd0);
      idle(2, 1);

      // unaligned target, and a flush-only kill
      cyc(0, 1, 2'b01, 32'h103, '0, 1);
      #2;
      check("aligned_target", imem_bus.addr, 32'h100);
      idle(2, 1);
      cyc(0, 1, 2'b00, 32'h500, '0, 1);
      idle(3, 1);

      // reset in the middle of DRAIN
      cyc(0, 0, 2'b00, '0, '0, 0);
      cyc(0, 1, 2'b01, 32'h300, '0, 0);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", 32'(imem_bus.req), 32'd0);
      check("mid_rst_addr", imem_bus.addr, 32'h0);
      check("mid_rst_instr", if_instr, 32'h0);
      check("mid_rst_pc4", if_pc4, 32'h0);
      check("mid_rst_valid", 32'(if_valid), 32'd0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic          s, k, r;
         logic [1:0]    src;
         s   = ($urandom_range(0, 99) < 20);
         k   = ($urandom_range(0, 99) < 10);
         r   = ($urandom_range(0, 99) < 70);
         src = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         cyc(s, k, src, $urandom, $urandom, r);
      end

      // let everything drain, then end on stall edges so nothing new enters
      idle(12, 1);
      cyc(1, 0, 2'b00, '0, '0, 1);
      cyc(1, 0, 2'b00, '0, '0, 1);
      check("no_lost_instr", 32'(exp_ins.size()), 32'd0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
